dsp_p_stage: RTL and testbench
==============================

Name: dsp_p_stage

Overview:
- Output stage that consumes the ALU result (`p`, `carryout`) and registers it.
- Runs pattern and inverted-pattern detection on the ALU result and registers the flags.
- Optionally derives overflow/underflow flags and auto-clears the P register on a pattern event.
- Sits directly after the ALU in the slice datapath and drives the slice P/CARRYOUT outputs and the detect flags.

Parameters:
- WIDTH, 48, datapath width; must equal the ALU WIDTH.
- PATTERN, 48'h0 (WIDTH bits), compare pattern.
- MASK, 48'h3FFF_FFFF_FFFF (WIDTH bits), per-bit mask; a 1 means "ignore this bit".
- AUTORESET, 0, auto-clear mode: 0 = none, 1 = reset on match, 2 = reset on not-match-after-match.

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears every register.
- cep  input  1  clock enable for all registers in this block.
- rstp  input  1  synchronous clear of all registers; overrides cep.
- alu_p  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carry out.
- p  output  WIDTH  registered result.
- carryout  output  1  registered carry.
- patterndetect  output  1  registered match of alu_p against PATTERN.
- patternbdetect  output  1  registered match of alu_p against ~PATTERN.
- patterndetectpast  output  1  patterndetect delayed by one enabled cycle.
- patternbdetectpast  output  1  patternbdetect delayed by one enabled cycle.
- overflow  output  1  overflow flag (feature-dependent, see Optional Feature).
- underflow  output  1  underflow flag (feature-dependent, see Optional Feature).

Behaviour:
- Reset: rst_n=0 asynchronously forces p, carryout, patterndetect, patternbdetect, patterndetectpast and patternbdetectpast to 0. Outputs stay 0 until the first enabled edge after release.
- Combinational match terms:
  - match = AND over i of ((alu_p[i] ~^ PATTERN[i]) | MASK[i])
  - matchb = AND over i of ((alu_p[i] ~^ ~PATTERN[i]) | MASK[i])
- Latency: 1 cycle from alu_p/alu_carryout to p/carryout/patterndetect/patternbdetect. The *past flags lag by one further enabled cycle.
- Per-edge priority, highest first:
  1. rst_n=0: async clear.
  2. rstp=1: clear all six registers, regardless of cep.
  3. cep=0: all registers hold.
  4. Autoreset condition true (and cep=1):
     - p, carryout, patterndetect and patternbdetect load 0.
     - patterndetectpast <= patterndetect and patternbdetectpast <= patternbdetect (the old values).
  5. Otherwise (cep=1):
     - p <= alu_p; carryout <= alu_carryout.
     - patterndetect <= match; patternbdetect <= matchb.
     - patterndetectpast <= patterndetect; patternbdetectpast <= patternbdetect.
- Autoreset condition, evaluated on the registered flags:
  - AUTORESET=0: never true.
  - AUTORESET=1: patterndetect=1.
  - AUTORESET=2: patterndetectpast=1 and patterndetect=0.
- An autoreset clear is a real state change: the next cycle's autoreset evaluation sees the cleared flags. A clear therefore never repeats on consecutive edges unless the clear itself produces a match.
- Constant PATTERN values are supported; the port width follows WIDTH.
- MASK all ones: match=matchb=1 for every input.

Optional Feature:
- Macro: DSP_P_OVERFLOW_DETECT_EN.
- Defined:
  - overflow = patterndetectpast & ~patterndetect & ~patternbdetect
  - underflow = patternbdetectpast & ~patterndetect & ~patternbdetect
  - Both are combinational from registers: no extra latency, 0 in reset.
- Undefined: overflow and underflow are tied to 0; the past registers remain.

Test Plan:
- rst_n=0 asserted mid-stream with p=48'h1234 loaded -> all outputs 0 immediately (before any clk edge); they remain 0 after release until the first cep=1 edge.
- Defaults, cep=1, alu_p=48'h0000_0000_1234, alu_carryout=1 -> after 1 edge: p=48'h1234, carryout=1, patterndetect=1, patternbdetect=0. Next edge with cep=0 and alu_p=48'h5 -> p still 48'h1234, patterndetectpast still 0.
- Overflow (macro defined): alu_p=48'h3FFF_FFFF_FFFF, then alu_p=48'h4000_0000_0000 on consecutive cep=1 edges -> after 2nd edge patterndetect=0, patternbdetect=0, patterndetectpast=1, overflow=1, underflow=0.
- Underflow (macro defined): alu_p=48'hC000_0000_0000, then alu_p=48'hBFFF_FFFF_FFFF -> after 2nd edge patternbdetectpast=1, underflow=1, overflow=0. With the macro undefined, both flags stay 0 throughout.
- AUTORESET=1, cep=1, alu_p held at 48'h10 -> edge1: p=48'h10, patterndetect=1; edge2: p=0 and patterndetect=0 despite alu_p=48'h10; edge3: p=48'h10 again.
- rstp=1 with cep=0, p=48'hABC loaded -> after next edge all registers 0. With rstp=1 and cep=1 in the same cycle, the clear wins: p=0.

Source files
------------

// File: rtl/dsp_p_stage.sv
// P output register stage: registers the ALU result, runs pattern / inverted-pattern
// detection and optional auto-clear. Optional overflow/underflow flags: DSP_P_OVERFLOW_DETECT_EN.
module dsp_p_stage #(
    parameter int               WIDTH     = 48,
    parameter logic [WIDTH-1:0] PATTERN   = 48'h0,
    parameter logic [WIDTH-1:0] MASK      = 48'h3FFF_FFFF_FFFF,
    parameter int               AUTORESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cep,
    input  logic             rstp,
    input  logic [WIDTH-1:0] alu_p,
    input  logic             alu_carryout,
    output logic [WIDTH-1:0] p,
    output logic             carryout,
    output logic             patterndetect,
    output logic             patternbdetect,
    output logic             patterndetectpast,
    output logic             patternbdetectpast,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] p_q;
    logic             carry_q;
    logic             pd_q;
    logic             pbd_q;
    logic             pdp_q;
    logic             pbdp_q;

    logic             match;
    logic             matchb;
    logic             autoreset_hit;

    // A set MASK bit forces that bit position to compare true.
    assign match  = &(~(alu_p ^ PATTERN)  | MASK);
    assign matchb = &(~(alu_p ^ ~PATTERN) | MASK);

    // Evaluated on the registered flags so a clear is seen by the next edge.
    always_comb begin
        autoreset_hit = 1'b0;
        case (AUTORESET)
            1:       autoreset_hit = pd_q;
            2:       autoreset_hit = pdp_q & ~pd_q;
            default: autoreset_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            carry_q <= 1'b0;
            pd_q    <= 1'b0;
            pbd_q   <= 1'b0;
            pdp_q   <= 1'b0;
            pbdp_q  <= 1'b0;
        end else if (rstp) begin
            p_q     <= '0;
            carry_q <= 1'b0;
            pd_q    <= 1'b0;
            pbd_q   <= 1'b0;
            pdp_q   <= 1'b0;
            pbdp_q  <= 1'b0;
        end else if (cep) begin
            pdp_q  <= pd_q;
            pbdp_q <= pbd_q;
            if (autoreset_hit) begin
                p_q     <= '0;
                carry_q <= 1'b0;
                pd_q    <= 1'b0;
                pbd_q   <= 1'b0;
            end else begin
                p_q     <= alu_p;
                carry_q <= alu_carryout;
                pd_q    <= match;
                pbd_q   <= matchb;
            end
        end
    end

    assign p                  = p_q;
    assign carryout           = carry_q;
    assign patterndetect      = pd_q;
    assign patternbdetect     = pbd_q;
    assign patterndetectpast  = pdp_q;
    assign patternbdetectpast = pbdp_q;

`ifdef DSP_P_OVERFLOW_DETECT_EN
    // Leaving the pattern region without landing on either pattern.
    assign overflow  = pdp_q  & ~pd_q & ~pbd_q;
    assign underflow = pbdp_q & ~pd_q & ~pbd_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_p_stage.sv
// Directed self-checking bench for dsp_p_stage: default, AUTORESET=1 and AUTORESET=2 instances.
module tb_dsp_p_stage;

    localparam int W = 48;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cep = 1'b0;
    logic         rstp = 1'b0;
    logic [W-1:0] alu_p = '0;
    logic         alu_carryout = 1'b0;

    logic [W-1:0] p0, p1, p2;
    logic         co0, co1, co2;
    logic         pd0, pd1, pd2;
    logic         pbd0, pbd1, pbd2;
    logic         pdp0, pdp1, pdp2;
    logic         pbdp0, pbdp1, pbdp2;
    logic         ov0, ov1, ov2;
    logic         un0, un1, un2;

    int pass_cnt = 0;
    int total_cnt = 0;

`ifdef DSP_P_OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dsp_p_stage #(.WIDTH(W), .AUTORESET(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp),
        .alu_p(alu_p), .alu_carryout(alu_carryout),
        .p(p0), .carryout(co0), .patterndetect(pd0), .patternbdetect(pbd0),
        .patterndetectpast(pdp0), .patternbdetectpast(pbdp0),
        .overflow(ov0), .underflow(un0)
    );

    dsp_p_stage #(.WIDTH(W), .AUTORESET(1)) u_ar1 (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp),
        .alu_p(alu_p), .alu_carryout(alu_carryout),
        .p(p1), .carryout(co1), .patterndetect(pd1), .patternbdetect(pbd1),
        .patterndetectpast(pdp1), .patternbdetectpast(pbdp1),
        .overflow(ov1), .underflow(un1)
    );

    dsp_p_stage #(.WIDTH(W), .AUTORESET(2)) u_ar2 (
        .clk(clk), .rst_n(rst_n), .cep(cep), .rstp(rstp),
        .alu_p(alu_p), .alu_carryout(alu_carryout),
        .p(p2), .carryout(co2), .patterndetect(pd2), .patternbdetect(pbd2),
        .patterndetectpast(pdp2), .patternbdetectpast(pbdp2),
        .overflow(ov2), .underflow(un2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cep = 1'b1; alu_p = 48'h1234; alu_carryout = 1'b1;
        step();
        total_cnt++;
        if (p0 !== 48'h1234) $display("FAIL reset_preload p: got %h want %h", p0, 48'h1234);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({p0, co0, pd0, pbd0, pdp0, pbdp0, ov0, un0} !== '0)
            $display("FAIL async_reset: p=%h co=%b pd=%b pbd=%b pdp=%b pbdp=%b ov=%b un=%b want all 0",
                     p0, co0, pd0, pbd0, pdp0, pbdp0, ov0, un0);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        cep = 1'b0;
        step();
        total_cnt++;
        if ({p0, co0, pd0, pbd0, pdp0, pbdp0} !== '0)
            $display("FAIL reset_hold_cep0: p=%h co=%b pd=%b want all 0", p0, co0, pd0);
        else pass_cnt++;
    endtask

    task automatic test_load_hold();
        cep = 1'b1; alu_p = 48'h0000_0000_1234; alu_carryout = 1'b1;
        step();
        total_cnt++;
        if (p0 !== 48'h1234) $display("FAIL load p: got %h want %h", p0, 48'h1234);
        else pass_cnt++;
        total_cnt++;
        if ({co0, pd0, pbd0} !== 3'b110)
            $display("FAIL load flags: co/pd/pbd got %b want 110", {co0, pd0, pbd0});
        else pass_cnt++;
        cep = 1'b0; alu_p = 48'h5; alu_carryout = 1'b0;
        step();
        total_cnt++;
        if (p0 !== 48'h1234 || co0 !== 1'b1) $display("FAIL hold p: got %h co %b want 1234 1", p0, co0);
        else pass_cnt++;
        total_cnt++;
        if (pdp0 !== 1'b0) $display("FAIL hold pdp: got %b want 0", pdp0);
        else pass_cnt++;
        cep = 1'b1;
        step();
        total_cnt++;
        if (p0 !== 48'h5 || co0 !== 1'b0 || pdp0 !== 1'b1)
            $display("FAIL resume: p=%h co=%b pdp=%b want 5 0 1", p0, co0, pdp0);
        else pass_cnt++;
        // Bits 47:46 = 11 is the inverted-pattern case under the default mask
        alu_p = 48'hFFFF_0000_0000;
        step();
        total_cnt++;
        if ({pd0, pbd0} !== 2'b01) $display("FAIL matchb: pd/pbd got %b want 01", {pd0, pbd0});
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        cep = 1'b1;
        alu_p = 48'h3FFF_FFFF_FFFF;
        step();
        alu_p = 48'h4000_0000_0000;
        step();
        total_cnt++;
        if ({pd0, pbd0, pdp0} !== 3'b001)
            $display("FAIL ovf_flags: pd/pbd/pdp got %b want 001", {pd0, pbd0, pdp0});
        else pass_cnt++;
        total_cnt++;
        if ({ov0, un0} !== {OVF_EN, 1'b0})
            $display("FAIL overflow: ov/un got %b want %b", {ov0, un0}, {OVF_EN, 1'b0});
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        cep = 1'b1;
        alu_p = 48'hC000_0000_0000;
        step();
        total_cnt++;
        if ({pd0, pbd0} !== 2'b01) $display("FAIL unf_first: pd/pbd got %b want 01", {pd0, pbd0});
        else pass_cnt++;
        alu_p = 48'hBFFF_FFFF_FFFF;
        step();
        total_cnt++;
        if ({pd0, pbd0, pbdp0} !== 3'b001)
            $display("FAIL unf_flags: pd/pbd/pbdp got %b want 001", {pd0, pbd0, pbdp0});
        else pass_cnt++;
        total_cnt++;
        if ({ov0, un0} !== {1'b0, OVF_EN})
            $display("FAIL underflow: ov/un got %b want %b", {ov0, un0}, {1'b0, OVF_EN});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({ov0, un0} !== 2'b00) $display("FAIL unf_clear: ov/un got %b want 00", {ov0, un0});
        else pass_cnt++;
    endtask

    task automatic test_autoreset_match();
        rstp = 1'b1; cep = 1'b1; alu_p = 48'h10; alu_carryout = 1'b1;
        step();
        rstp = 1'b0;
        step();
        total_cnt++;
        if (p1 !== 48'h10 || pd1 !== 1'b1) $display("FAIL ar1_edge1: p=%h pd=%b want 10 1", p1, pd1);
        else pass_cnt++;
        step();
        total_cnt++;
        if (p1 !== 48'h0 || pd1 !== 1'b0 || co1 !== 1'b0 || pdp1 !== 1'b1)
            $display("FAIL ar1_edge2: p=%h pd=%b co=%b pdp=%b want 0 0 0 1", p1, pd1, co1, pdp1);
        else pass_cnt++;
        step();
        total_cnt++;
        if (p1 !== 48'h10 || pd1 !== 1'b1) $display("FAIL ar1_edge3: p=%h pd=%b want 10 1", p1, pd1);
        else pass_cnt++;
        total_cnt++;
        if (p0 !== 48'h10) $display("FAIL ar0_no_clear: p=%h want 10", p0);
        else pass_cnt++;
    endtask

    task automatic test_autoreset_notmatch();
        rstp = 1'b1; cep = 1'b1; alu_p = 48'h10; alu_carryout = 1'b0;
        step();
        rstp = 1'b0;
        step();
        alu_p = 48'h4000_0000_0000;
        step();
        total_cnt++;
        if (p2 !== 48'h4000_0000_0000 || pd2 !== 1'b0 || pdp2 !== 1'b1)
            $display("FAIL ar2_leave: p=%h pd=%b pdp=%b want 400000000000 0 1", p2, pd2, pdp2);
        else pass_cnt++;
        alu_p = 48'h10;
        step();
        total_cnt++;
        if (p2 !== 48'h0 || pd2 !== 1'b0 || pdp2 !== 1'b0)
            $display("FAIL ar2_clear: p=%h pd=%b pdp=%b want 0 0 0", p2, pd2, pdp2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (p2 !== 48'h10 || pd2 !== 1'b1) $display("FAIL ar2_reload: p=%h pd=%b want 10 1", p2, pd2);
        else pass_cnt++;
    endtask

    task automatic test_rstp();
        cep = 1'b1; rstp = 1'b0; alu_p = 48'hABC; alu_carryout = 1'b1;
        step();
        step();
        total_cnt++;
        if (p0 !== 48'hABC || pdp0 !== 1'b1) $display("FAIL rstp_preload: p=%h pdp=%b want abc 1", p0, pdp0);
        else pass_cnt++;
        cep = 1'b0; rstp = 1'b1;
        step();
        total_cnt++;
        if ({p0, co0, pd0, pbd0, pdp0, pbdp0} !== '0)
            $display("FAIL rstp_cep0: p=%h co=%b pd=%b pdp=%b want all 0", p0, co0, pd0, pdp0);
        else pass_cnt++;
        rstp = 1'b0; cep = 1'b1;
        step();
        rstp = 1'b1;
        step();
        total_cnt++;
        if (p0 !== 48'h0 || co0 !== 1'b0 || pd0 !== 1'b0)
            $display("FAIL rstp_cep1: p=%h co=%b pd=%b want 0 0 0", p0, co0, pd0);
        else pass_cnt++;
        rstp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_hold();
        test_overflow();
        test_underflow();
        test_autoreset_match();
        test_autoreset_notmatch();
        test_rstp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
